// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one level-sensitive UART transmitter among NUM_REQ byte producers.
// Optional SEND-state watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 60000,
  localparam int unsigned IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic [NUM_REQ-1:0]          done,
  output logic                        uart_start,
  output logic [DATA_W-1:0]           uart_tx_data,
  input  logic                        uart_tx_done,
  output logic                        busy,
  output logic [IDW-1:0]              grant_id,
  output logic                        timeout_err
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_tx_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                          state;
  logic   [IDW-1:0]                last_grant;
  logic   [IDW-1:0]                sel_id;
  logic                            sel_valid;
  logic   [DATA_W-1:0]             sel_data;
  logic   [NUM_REQ-1:0][DATA_W-1:0] req_bytes;

  assign req_bytes = req_data;

  // Search starts just after the previous winner and wraps modulo NUM_REQ.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = '0;
    sel_data  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      int unsigned    pos;
      logic [IDW-1:0] idx;
      pos = (32'(last_grant) + i) % NUM_REQ;
      idx = pos[IDW-1:0];
      if (!sel_valid && req[idx]) begin
        sel_valid = 1'b1;
        sel_id    = idx;
        sel_data  = req_bytes[idx];
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] send_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= IDW'(NUM_REQ - 1);
      grant_id     <= '0;
      uart_start   <= 1'b0;
      uart_tx_data <= '0;
      ack          <= '0;
      done         <= '0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      send_cnt     <= '0;
`endif
    end else begin
      ack         <= '0;
      done        <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            uart_tx_data <= sel_data;
            grant_id     <= sel_id;
            ack[sel_id]  <= 1'b1;
            uart_start   <= 1'b1;
            busy         <= 1'b1;
            state        <= SEND;
`ifdef UART_ARB_TIMEOUT_EN
            send_cnt     <= '0;
`endif
          end
        end
        SEND: begin
          // tx_done takes priority over a watchdog expiry in the same cycle.
          if (uart_tx_done) begin
            done[grant_id] <= 1'b1;
            uart_start     <= 1'b0;
            last_grant     <= grant_id;
            state          <= GAP;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (send_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            uart_start  <= 1'b0;
            last_grant  <= grant_id;
            state       <= GAP;
          end else begin
            send_cnt <= send_cnt + CNT_W'(1);
          end
`endif
        end
        GAP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus queues expected ack/done/timeout events,
// a negedge monitor pops and compares them as the DUT emits them.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  done;
  logic        uart_start;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_done;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .done(done),
    .uart_start(uart_start), .uart_tx_data(uart_tx_data), .uart_tx_done(uart_tx_done),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  localparam logic [1:0] EV_ACK  = 2'd0;
  localparam logic [1:0] EV_DONE = 2'd1;
  localparam logic [1:0] EV_TO   = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] id;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  bit  uart_auto = 0;
  int  auto_cnt = 0;
  logic prev_start = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [1:0] id, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.id   = id;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input logic [1:0] kind, input logic [1:0] id, input logic [7:0] data);
    ev_t e;
    ev_t a;
    a.kind = kind;
    a.id   = id;
    a.data = data;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d id=%0d data=%0h expected none", kind, id, data);
    end else begin
      e = exp_q.pop_front();
      if (e !== a) begin
        n_fail++;
        $display("FAIL event_order: got kind=%0d id=%0d data=%0h expected kind=%0d id=%0d data=%0h",
                 a.kind, a.id, a.data, e.kind, e.id, e.data);
      end
    end
  endtask

  // Monitor: every ack/done/timeout pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (|ack) chk("gap_before_start", {31'd0, prev_start}, 32'd0);
      for (int i = 0; i < 4; i++) begin
        if (ack[i])  check_ev(EV_ACK, 2'(i), uart_tx_data);
        if (done[i]) check_ev(EV_DONE, 2'(i), 8'h00);
      end
      if (timeout_err) check_ev(EV_TO, grant_id, 8'h00);
    end
    prev_start = uart_start;
  end

  // UART model: raises tx_done for one cycle after uart_start has been seen for 3 cycles.
  initial forever begin
    @(posedge clk);
    #2;
    if (uart_auto) begin
      uart_tx_done = 1'b0;
      if (uart_start) begin
        auto_cnt++;
        if (auto_cnt == 3) begin
          uart_tx_done = 1'b1;
          auto_cnt = 0;
        end
      end else begin
        auto_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req = '0;
    uart_tx_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ack(input logic [3:0] mask, input string nm);
    bit got = 0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      got = |(ack & mask);
    end
    chk(nm, {31'd0, got}, 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    bit idle = 0;
    for (int n = 0; n < 300 && !idle; n++) begin
      @(negedge clk);
      idle = !busy;
    end
    chk(nm, {31'd0, idle}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    req = '0;
    req_data = '0;
    uart_tx_done = 1'b0;
    apply_reset();

    // Reset values
    chk("rst_uart_start", {31'd0, uart_start}, 32'd0);
    chk("rst_tx_data", {24'd0, uart_tx_data}, 32'd0);
    chk("rst_ack_done", {24'd0, ack, done}, 32'd0);
    chk("rst_busy_to", {30'd0, busy, timeout_err}, 32'd0);
    chk("rst_grant_id", {30'd0, grant_id}, 32'd0);

    // 1: single request, manual tx_done
    req_data = 32'h000000A5;
    req = 4'b0001;
    push(EV_ACK, 2'd0, 8'hA5);
    tick();
    req = 4'b0000;
    chk("t1_start", {31'd0, uart_start}, 32'd1);
    chk("t1_data", {24'd0, uart_tx_data}, 32'hA5);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    repeat (3) tick();
    chk("t1_start_held", {31'd0, uart_start}, 32'd1);
    uart_tx_done = 1'b1;
    push(EV_DONE, 2'd0, 8'h00);
    tick();
    uart_tx_done = 1'b0;
    chk("t1_done", {28'd0, done}, 32'h1);
    chk("t1_start_drop", {31'd0, uart_start}, 32'd0);
    chk("t1_gap_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);

    // 2: all four request at once
    apply_reset();
    uart_auto = 1;
    req_data = 32'h44332211;
    for (int i = 0; i < 4; i++) begin
      push(EV_ACK, 2'(i), 8'(8'h11 * (i + 1)));
      push(EV_DONE, 2'(i), 8'h00);
    end
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_ack(4'(1 << i), "t2_ack_wait");
      req[i] = 1'b0;
    end
    wait_idle("t2_idle_wait");

    // 3: fairness between requesters 0 and 2
    apply_reset();
    req_data = 32'h55C233A0;
    for (int f = 0; f < 6; f++) begin
      push(EV_ACK, (f % 2 == 0) ? 2'd0 : 2'd2, (f % 2 == 0) ? 8'hA0 : 8'hC2);
      push(EV_DONE, (f % 2 == 0) ? 2'd0 : 2'd2, 8'h00);
    end
    req = 4'b0101;
    for (int f = 0; f < 6; f++) wait_ack(4'b1111, "t3_ack_wait");
    req = 4'b0000;
    wait_idle("t3_idle_wait");
    chk("t3_last_grant", {30'd0, grant_id}, 32'd2);

    // 4: reset in the middle of SEND, then stale tx_done
    uart_auto = 0;
    apply_reset();
    req_data = 32'h00005B00;
    req = 4'b0010;
    push(EV_ACK, 2'd1, 8'h5B);
    tick();
    req = 4'b0000;
    repeat (2) tick();
    chk("t4_start_before", {31'd0, uart_start}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t4_async_start", {31'd0, uart_start}, 32'd0);
    chk("t4_async_busy", {31'd0, busy}, 32'd0);
    chk("t4_async_data", {24'd0, uart_tx_data}, 32'd0);
    chk("t4_async_grant", {30'd0, grant_id}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (4) tick();
    uart_tx_done = 1'b1;
    tick();
    uart_tx_done = 1'b0;
    tick();
    chk("t4_stale_done", {28'd0, done}, 32'd0);
    chk("t4_stale_busy", {31'd0, busy}, 32'd0);
    req_data = 32'h00006C00;
    push(EV_ACK, 2'd1, 8'h6C);
    push(EV_DONE, 2'd1, 8'h00);
    uart_auto = 1;
    req = 4'b0010;
    wait_ack(4'b0010, "t4_ack_wait");
    req = 4'b0000;
    wait_idle("t4_idle_wait");
    chk("t4_grant", {30'd0, grant_id}, 32'd1);

    // 5: stray tx_done while idle, request withdrawn before ack
    uart_auto = 0;
    repeat (2) tick();
    uart_tx_done = 1'b1;
    tick();
    uart_tx_done = 1'b0;
    chk("t5_stray_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("t5_stray_quiet", {24'd0, done, 3'd0, uart_start}, 32'd0);
    uart_auto = 1;
    req_data = 32'h99000077;
    push(EV_ACK, 2'd0, 8'h77);
    push(EV_DONE, 2'd0, 8'h00);
    req = 4'b0001;
    tick();
    chk("t5_ack0", {28'd0, ack}, 32'h1);
    req = 4'b1000;
    tick();
    req = 4'b0000;
    wait_idle("t5_idle_wait");
    repeat (3) tick();
    chk("t5_no_ack3", {27'd0, busy, ack}, 32'd0);
    uart_auto = 0;

    // 6: watchdog
    apply_reset();
    req_data = 32'h003C0000;
    req = 4'b0100;
    push(EV_ACK, 2'd2, 8'h3C);
    tick();
    req = 4'b0000;
`ifdef UART_ARB_TIMEOUT_EN
    repeat (99) tick();
    chk("t6_pre_expiry", {30'd0, uart_start, timeout_err}, 32'h2);
    push(EV_TO, 2'd2, 8'h00);
    tick();
    chk("t6_timeout_err", {31'd0, timeout_err}, 32'd1);
    chk("t6_no_done", {28'd0, done}, 32'd0);
    chk("t6_start_drop", {30'd0, uart_start, busy}, 32'h1);
    tick();
    chk("t6_to_cleared", {30'd0, busy, timeout_err}, 32'd0);
    req_data = 32'h003D0000;
    req = 4'b0100;
    push(EV_ACK, 2'd2, 8'h3D);
    tick();
    req = 4'b0000;
    repeat (99) tick();
    uart_tx_done = 1'b1;
    push(EV_DONE, 2'd2, 8'h00);
    tick();
    uart_tx_done = 1'b0;
    chk("t6_tie_done", {27'd0, done, timeout_err}, 32'h08);
    tick();
`else
    repeat (200) tick();
    chk("t6_start_held", {30'd0, uart_start, busy}, 32'h3);
    chk("t6_no_timeout", {31'd0, timeout_err}, 32'd0);
    uart_tx_done = 1'b1;
    push(EV_DONE, 2'd2, 8'h00);
    tick();
    uart_tx_done = 1'b0;
    chk("t6_done", {28'd0, done}, 32'h4);
    tick();
`endif
    wait_idle("t6_idle_wait");
    repeat (3) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
